// File: rtl/shake256_sponge_ctrl.sv
// SHAKE256 sponge controller (rate 1088 bits / 136 bytes, capacity 512).
// Owns the 1600-bit sponge state. It absorbs message blocks with SHAKE
// padding and runs one external KECCAK_f permutation per block through a
// start/done handshake. It then squeezes the requested number of 136-byte
// output blocks.
// Sponge byte i lives at state[1599-8i -: 8]; the rate is state[1599:512].
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start, out_blocks   begin a hash (IDLE only); squeeze block count (0 -> 1)
//   in_valid/in_ready   message block handshake
//   in_block            message block, byte i = in_block[1087-8i -: 8]
//   in_last             final message block marker
//   in_last_bytes       valid bytes in the final block (>136 treated as 136)
//   out_valid/out_ready squeeze block handshake
//   out_block           rate part of the sponge state
//   perm_start          one-cycle launch pulse to KECCAK_f
//   perm_state_in       sponge state presented to KECCAK_f
//   perm_state_out      KECCAK_f result, valid with perm_done
//   perm_done           one-cycle completion pulse from KECCAK_f
//   busy                controller is not idle
//   done                one-cycle pulse after the final squeeze handshake
module shake256_sponge_ctrl (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    out_blocks,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1087:0] in_block,
  input  logic          in_last,
  input  logic [7:0]    in_last_bytes,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1087:0] out_block,
  output logic          perm_start,
  output logic [1599:0] perm_state_in,
  input  logic [1599:0] perm_state_out,
  input  logic          perm_done,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ABSORB  = 3'd1,
    S_PERM_A  = 3'd2,
    S_PAD     = 3'd3,
    S_SQUEEZE = 3'd4,
    S_PERM_S  = 3'd5
  } fsm_e;

  // Standalone pad block: byte 0 ^= 0x1F, byte 135 ^= 0x80.
  localparam logic [1599:0] PAD_MASK = {8'h1F, {134{8'h00}}, 8'h80, 512'b0};

  fsm_e          fsm_q, fsm_d;
  logic [1599:0] sponge_q, sponge_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          pad_pend_q, pad_pend_d;
  logic          pad_done_q, pad_done_d;
  logic          launched_q, launched_d;
  logic          done_q, done_d;

  // Zero the bytes past the message end of a short final block and add the
  // SHAKE padding in place. A full final block is returned untouched; its
  // padding goes into a separate pad block.
  function automatic logic [1087:0] shape_block(input logic [1087:0] blk,
                                                input logic          last,
                                                input logic [7:0]    nbytes);
    logic [1087:0] res;
    logic [7:0]    len;
    len = (nbytes > 8'd136) ? 8'd136 : nbytes;
    res = blk;
    if (last && (len != 8'd136)) begin
      for (int i = 0; i < 136; i++) begin
        if (i >= int'(len)) res[1087-8*i -: 8] = 8'h00;
        if (i == int'(len)) res[1087-8*i -: 8] = res[1087-8*i -: 8] ^ 8'h1F;
      end
      // Byte 135; with len == 135 this merges with the 0x1F to give 0x9F.
      res[7:0] = res[7:0] ^ 8'h80;
    end
    return res;
  endfunction

  always_comb begin
    fsm_d      = fsm_q;
    sponge_d   = sponge_q;
    cnt_d      = cnt_q;
    pad_pend_d = pad_pend_q;
    pad_done_d = pad_done_q;
    launched_d = 1'b0;
    done_d     = 1'b0;
    unique case (fsm_q)
      S_IDLE: begin
        if (start) begin
          sponge_d   = '0;
          cnt_d      = (out_blocks == 8'd0) ? 8'd1 : out_blocks;
          pad_pend_d = 1'b0;
          pad_done_d = 1'b0;
          fsm_d      = S_ABSORB;
        end
      end
      S_ABSORB: begin
        if (in_valid) begin
          sponge_d[1599:512] = sponge_q[1599:512] ^
                               shape_block(in_block, in_last, in_last_bytes);
          if (in_last) begin
            if (in_last_bytes >= 8'd136) pad_pend_d = 1'b1;
            else                         pad_done_d = 1'b1;
          end
          fsm_d = S_PERM_A;
        end
      end
      S_PERM_A, S_PERM_S: begin
        // launched_q marks that the start pulse has already gone out.
        launched_d = 1'b1;
        if (perm_done) begin
          sponge_d   = perm_state_out;
          launched_d = 1'b0;
          if (fsm_q == S_PERM_S) fsm_d = S_SQUEEZE;
          else if (pad_pend_q)   fsm_d = S_PAD;
          else if (pad_done_q)   fsm_d = S_SQUEEZE;
          else                   fsm_d = S_ABSORB;
        end
      end
      S_PAD: begin
        sponge_d   = sponge_q ^ PAD_MASK;
        pad_pend_d = 1'b0;
        pad_done_d = 1'b1;
        fsm_d      = S_PERM_A;
      end
      S_SQUEEZE: begin
        if (out_ready) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q <= 8'd1) begin
            done_d = 1'b1;
            fsm_d  = S_IDLE;
          end else begin
            fsm_d = S_PERM_S;
          end
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q      <= S_IDLE;
      sponge_q   <= '0;
      cnt_q      <= '0;
      pad_pend_q <= 1'b0;
      pad_done_q <= 1'b0;
      launched_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      sponge_q   <= sponge_d;
      cnt_q      <= cnt_d;
      pad_pend_q <= pad_pend_d;
      pad_done_q <= pad_done_d;
      launched_q <= launched_d;
      done_q     <= done_d;
    end
  end

  assign in_ready      = (fsm_q == S_ABSORB);
  assign out_valid     = (fsm_q == S_SQUEEZE);
  assign out_block     = sponge_q[1599:512];
  assign perm_state_in = sponge_q;
  assign perm_start    = ((fsm_q == S_PERM_A) || (fsm_q == S_PERM_S)) && !launched_q;
  assign busy          = (fsm_q != S_IDLE);
  assign done          = done_q;

endmodule
